// File: rtl/subtree_rr_scheduler.sv
// Round-robin grant scheduler for the children of one hierarchy node, with a hold limit.
// Optional grant/timeout statistics counters are enabled by defining SUBTREE_SCHED_STATS_EN.
module subtree_rr_scheduler #(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout_pulse
`ifdef SUBTREE_SCHED_STATS_EN
  ,
  output logic [15:0]        grant_total,
  output logic [7:0]         timeout_total
`endif
);

  localparam int HC_W = $clog2(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [ID_W-1:0]    sel;
  logic [NUM_REQ-1:0] sel_onehot;
  logic               release_done;
  logic               release_to;
  logic               grant_start;

  // Rotating-priority search: first requester at or after ptr, wrapping at NUM_REQ-1.
  always_comb begin
    logic [ID_W:0]   idx;
    logic [ID_W-1:0] cand;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      cand = idx[ID_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel_dec
    assign sel_onehot[gi] = (sel == ID_W'(gi));
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    gnt_d        = '0;
    gnt_valid_d  = 1'b0;
    gnt_id_d     = '0;
    timeout_d    = 1'b0;
    release_done = 1'b0;
    release_to   = 1'b0;
    grant_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          state_d     = GRANT;
          gnt_d       = sel_onehot;
          gnt_valid_d = 1'b1;
          gnt_id_d    = sel;
          hold_cnt_d  = '0;
          grant_start = 1'b1;
        end
      end
      GRANT: begin
        // A completion in the final hold cycle wins over the timeout.
        release_done = done[gnt_id_q] | ~req[gnt_id_q];
        release_to   = (hold_cnt_q == HC_W'(MAX_HOLD-1)) & ~release_done;
        if (release_done || release_to) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          timeout_d  = release_to;
          ptr_d      = (gnt_id_q == ID_W'(NUM_REQ-1)) ? '0 : gnt_id_q + ID_W'(1);
        end else begin
          gnt_d       = gnt_q;
          gnt_valid_d = 1'b1;
          gnt_id_d    = gnt_id_q;
          hold_cnt_d  = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt           = gnt_q;
  assign gnt_valid     = gnt_valid_q;
  assign gnt_id        = gnt_id_q;
  assign timeout_pulse = timeout_q;

`ifdef SUBTREE_SCHED_STATS_EN
  logic [15:0] grant_total_q, grant_total_d;
  logic [7:0]  timeout_total_q, timeout_total_d;

  always_comb begin
    grant_total_d   = grant_total_q;
    timeout_total_d = timeout_total_q;
    if (grant_start && grant_total_q != 16'hFFFF) begin
      grant_total_d = grant_total_q + 16'd1;
    end
    if (release_to && timeout_total_q != 8'hFF) begin
      timeout_total_d = timeout_total_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_total_q   <= '0;
      timeout_total_q <= '0;
    end else begin
      grant_total_q   <= grant_total_d;
      timeout_total_q <= timeout_total_d;
    end
  end

  assign grant_total   = grant_total_q;
  assign timeout_total = timeout_total_q;
`endif

  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// Scoreboard bench for subtree_rr_scheduler: directed stimulus pushes expected grants,
// a negedge monitor reconstructs each grant and checks it against the queue.
module tb_subtree_rr_scheduler;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] stim_done = '0;
  logic [N-1:0] resp_done = '0;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_id;
  logic         timeout_pulse;
`ifdef SUBTREE_SCHED_STATS_EN
  logic [15:0]  grant_total;
  logic [7:0]   timeout_total;
`endif

  assign done = stim_done | resp_done;

  subtree_rr_scheduler #(.NUM_REQ(N), .MAX_HOLD(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id),
    .timeout_pulse(timeout_pulse)
`ifdef SUBTREE_SCHED_STATS_EN
    ,
    .grant_total(grant_total),
    .timeout_total(timeout_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int len;   // -1: grant expected to be abandoned by reset
    int to;
    int gap;   // -1: preceding idle gap not checked
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   pops = 0;
  int   done_cyc = 0;
  int   resp_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int len, input int to, input int gap);
    exp_t e;
    e.id = id; e.len = len; e.to = to; e.gap = gap;
    q.push_back(e);
  endtask

  // Wait for the monitor to retire n grants, then drop req inside the dead cycle.
  task automatic wait_pops(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (pops >= n) break;
    end
    chk("grant_wait", (pops >= n), 1);
    req = '0;
  endtask

  // Responder: grantee raises done on grant cycle done_cyc (1-based).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gnt_valid) resp_k++;
      else resp_k = 0;
      resp_done = (done_cyc != 0 && resp_k == done_cyc) ? gnt : '0;
    end
  end

  // Monitor
  bit   in_grant = 0;
  int   cur_id, cur_len, idle_cnt = 0, obs_gap;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (in_grant) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_grant: id %0d abandoned with no expectation", cur_id);
        end else begin
          e = q.pop_front();
          pops++;
          chk("abandon_id", cur_id, e.id);
          chk("abandon_expected", e.len, -1);
        end
        in_grant = 0;
      end
      idle_cnt = 0;
    end else if (gnt_valid) begin
      if (!in_grant) begin
        in_grant = 1;
        cur_id = int'(gnt_id);
        cur_len = 1;
        obs_gap = idle_cnt;
        chk("gnt_onehot", gnt, 32'd1 << gnt_id);
      end else begin
        cur_len++;
        chk("gnt_id_stable", gnt_id, cur_id);
      end
      chk("pulse_in_grant", timeout_pulse, 0);
    end else begin
      chk("idle_gnt", gnt, 0);
      chk("idle_gnt_id", gnt_id, 0);
      if (in_grant) begin
        in_grant = 0;
        idle_cnt = 1;
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_grant: id %0d len %0d with no expectation", cur_id, cur_len);
        end else begin
          e = q.pop_front();
          pops++;
          $display("grant id=%0d len=%0d timeout=%0d gap=%0d (exp id=%0d len=%0d timeout=%0d)",
                   cur_id, cur_len, timeout_pulse, obs_gap, e.id, e.len, e.to);
          chk("grant_id", cur_id, e.id);
          chk("grant_len", cur_len, e.len);
          chk("timeout_pulse", timeout_pulse, e.to);
          if (e.gap >= 0) chk("idle_gap", obs_gap, e.gap);
        end
      end else begin
        idle_cnt++;
        chk("idle_pulse", timeout_pulse, 0);
      end
    end
  end

  task automatic sync_reset();
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_gnt", gnt, 0);
    chk("reset_gnt_valid", gnt_valid, 0);
    chk("reset_gnt_id", gnt_id, 0);
    chk("reset_timeout", timeout_pulse, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Single requester, no done: 16-cycle hold then forced release, ptr -> 3.
    push(2, 16, 1, -1);
    tick();
    req = 5'b00100;
    enable = 1'b1;
    wait_pops(1);
    push(3, 2, 0, -1);
    done_cyc = 2;
    tick();
    req = 5'b01001;
    wait_pops(2);
`ifdef SUBTREE_SCHED_STATS_EN
    chk("grant_total_t1", grant_total, 2);
    chk("timeout_total_t1", timeout_total, 1);
`endif

    // All requesting, done on 3rd cycle: order 0,1,2,3,4,0 with 1-cycle gaps.
    sync_reset();
    base = pops;
    push(0, 3, 0, -1);
    push(1, 3, 0, 1);
    push(2, 3, 0, 1);
    push(3, 3, 0, 1);
    push(4, 3, 0, 1);
    push(0, 3, 0, 1);
    done_cyc = 3;
    tick();
    req = 5'b11111;
    wait_pops(base + 6);

    // ptr=1: child 4 wins, wrap sends next grant to 0.
    base = pops;
    push(4, 2, 0, -1);
    push(0, 2, 0, 1);
    done_cyc = 2;
    tick();
    req = 5'b10001;
    wait_pops(base + 2);

    // enable dropped mid-grant: grant finishes on done, nothing new while disabled.
    base = pops;
    push(1, 6, 0, -1);
    done_cyc = 6;
    tick();
    req = 5'b00010;
    repeat (3) tick();
    enable = 1'b0;
    req = 5'b11111;
    repeat (12) tick();
    chk("no_grant_while_disabled", pops, base + 1);
    req = '0;
    enable = 1'b1;

    // Stray done bits ignored; done coinciding with timeout gives no pulse.
    tick();
    stim_done = 5'b11111;
    tick();
    stim_done = '0;
    base = pops;
    push(3, 16, 0, -1);
    done_cyc = 16;
    req = 5'b01000;
    repeat (4) tick();
    stim_done = 5'b00010;
    tick();
    stim_done = '0;
    wait_pops(base + 1);
`ifdef SUBTREE_SCHED_STATS_EN
    chk("grant_total_t5", grant_total, 10);
    chk("timeout_total_t5", timeout_total, 0);
`endif

    // Asynchronous reset mid-grant; restart from ptr=0 (child 1 beats child 4).
    base = pops;
    push(0, -1, 0, -1);
    done_cyc = 0;
    tick();
    req = 5'b00001;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_gnt_valid", gnt_valid, 0);
    chk("async_gnt_id", gnt_id, 0);
    chk("async_timeout", timeout_pulse, 0);
`ifdef SUBTREE_SCHED_STATS_EN
    chk("async_grant_total", grant_total, 0);
    chk("async_timeout_total", timeout_total, 0);
`endif
    repeat (2) tick();
    push(1, 2, 0, -1);
    done_cyc = 2;
    req = 5'b10010;
    rst_n = 1'b1;
    wait_pops(base + 2);

    repeat (5) tick();
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/subtree_rr_scheduler.md
Name: subtree_rr_scheduler

Overview:
- Round-robin scheduler that shares one resource slot among the child instances of a hierarchy node. Default is 5 children, inst_0..inst_4.
- Each child raises a request. The scheduler grants one child at a time and holds the grant until the child signals done or a hold limit expires.
- Sits beside the child instances in each subtree node and drives their enable/grant lines.

Parameters:
- NUM_REQ, 5, number of child requesters; legal range 2..16.
- MAX_HOLD, 16, maximum cycles a grant is held before forced release; must be >= 2.
- ID_W, $clog2(NUM_REQ), width of gnt_id; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  arbitration enable; low blocks new grants only.
- req  input  NUM_REQ  per-child request level.
- done  input  NUM_REQ  per-child completion strobe; only the bit of the current grantee is honoured.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  ID_W  index of current grantee; 0 when gnt_valid=0.
- timeout_pulse  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt=0, gnt_valid=0, gnt_id=0, timeout_pulse=0.
  - State=IDLE, ptr=0, hold_cnt=0.
  - Outputs clear immediately, not at the next edge; any in-flight grant is abandoned.
- States: IDLE and GRANT.
- IDLE:
  - If enable=1 and req!=0, select the first set req bit scanning ptr, ptr+1, ... with wrap NUM_REQ-1 -> 0.
  - At the next edge: gnt[sel]=1, gnt_id=sel, hold_cnt=0, state->GRANT.
  - Latency: req sampled in cycle N gives a grant visible in cycle N+1.
  - enable=0 or req=0: stay in IDLE, outputs 0.
- GRANT, evaluated every cycle for grantee g:
  - release_done = done[g] | ~req[g].
  - release_to = (hold_cnt == MAX_HOLD-1) & ~release_done.
  - On either release, at the next edge: gnt=0, gnt_id=0, ptr=(g+1) mod NUM_REQ, hold_cnt=0, state->IDLE.
  - timeout_pulse=1 for exactly that edge's cycle if release_to; otherwise 0.
  - With neither release: hold_cnt increments; it saturates by construction, never exceeding MAX_HOLD-1.
- Maximum grant length is MAX_HOLD cycles.
- There is always at least one cycle with gnt=0 between consecutive grants, including to the same child.
- done and timeout in the same cycle: treated as done; no timeout_pulse.
- done bits of non-granted children, and done while in IDLE, are ignored.
- enable dropped during GRANT: no preemption; the current grant completes normally and no new grant is issued until enable=1.
- ptr advances only on release, so a single requester re-wins after the dead cycle. Starvation-free: every waiting child is granted within (NUM_REQ-1)*(MAX_HOLD+1) cycles.
- gnt is always one-hot or zero. An assertion must flag a violation.

Optional Feature:
- Macro SUBTREE_SCHED_STATS_EN.
- Defined: adds two outputs.
  - grant_total, output, 16 bits: counts grants issued, saturates at 16'hFFFF.
  - timeout_total, output, 8 bits: counts timeout_pulse events, saturates at 8'hFF.
  - Both reset to 0 and update on the same edge as the grant or release.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req=5'b00100, enable=1, done=0 -> cycle+1: gnt=5'b00100, gnt_id=2.
  - With no done: gnt holds 16 cycles, drops with timeout_pulse=1 for one cycle, ptr=3.
- req=5'b11111 held, each grantee asserts done on its 3rd grant cycle -> grant order 0,1,2,3,4,0.
  - Each grant is 3 cycles long, separated by exactly 1 idle cycle.
- Grant to child 4, done[4]=1 -> gnt drops, ptr wraps to 0; with req=5'b10001 the next grant is 0.
- Child 1 granted, enable=0 at hold_cnt=2, done[1]=1 at hold_cnt=5 -> release at cycle 6; no further grant while enable=0 even with req=5'b11111.
- done[1] pulsed while child 3 granted -> ignored, grant continues.
  - done[3] and the timeout condition in the same cycle -> release, timeout_pulse=0.
- rst_n low mid-grant, asynchronous to clk -> gnt=0 and gnt_valid=0 immediately; after release, arbitration restarts from ptr=0.
  - With SUBTREE_SCHED_STATS_EN, grant_total and timeout_total read 0.
